// File: rtl/adma_engine_if.sv
// Bus bundle between the ADMA2 descriptor engine and its memory / data-mover side.
// cont carries the CONTINUE pulse because continue is a reserved word.
interface adma_engine_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              cont;
    logic              stop_req;
    logic [ADDR_W-1:0] desc_base;
    logic              desc_req;
    logic [ADDR_W-1:0] desc_addr;
    logic              desc_ack;
    logic [ADDR_W+31:0] desc_data;
    logic              xfer_req;
    logic [ADDR_W-1:0] xfer_addr;
    logic              xfer_beat;
    logic              xfer_err;
    logic [1:0]        state;
    logic              desc_int;
    logic              done;
    logic              err_int;
    logic [1:0]        err_state;

    modport master (
        input  start, cont, stop_req, desc_base, desc_ack, desc_data, xfer_beat, xfer_err,
        output desc_req, desc_addr, xfer_req, xfer_addr, state, desc_int, done, err_int, err_state
    );

    modport slave (
        output start, cont, stop_req, desc_base, desc_ack, desc_data, xfer_beat, xfer_err,
        input  desc_req, desc_addr, xfer_req, xfer_addr, state, desc_int, done, err_int, err_state
    );
endinterface

// File: rtl/adma_engine.sv
// Clocked ADMA2 descriptor engine: walks the descriptor table (stop / fetch / change
// address / transfer), drives the beat handshake and raises completion and error flags.
module adma_engine #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int BEAT_BYTES = 4
) (
    input logic           clk,
    input logic           reset,
    adma_engine_if.master bus
);
    localparam int DESC_BYTES = (ADDR_W + 32) / 8;
    localparam int CNT_W      = LEN_W + 1;
    localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(DESC_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BEAT_BYTES);
    localparam logic [CNT_W-1:0]  CNT_STEP  = CNT_W'(BEAT_BYTES);
    localparam logic [CNT_W-1:0]  CNT_MASK  = CNT_W'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_FDS  = 2'b01,
        ST_CADR = 2'b10,
        ST_TFR  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] xfer_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [LEN_W-1:0]  d_len;
    act_t              d_act;
    logic              d_end;
    logic              d_int;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  rem_init;
    logic              stop_latch;
    logic              desc_req;
    logic              xfer_req;
    logic              desc_int;
    logic              done;
    logic              err_int;
    logic [1:0]        err_state;
    logic              unused_attr;

    // A zero length field stands for the full 2^LEN_W bytes.
    assign rem_init    = (d_len == '0) ? (CNT_W'(1) << LEN_W) : {1'b0, d_len};
    assign unused_attr = ^{bus.desc_data[15:6], bus.desc_data[3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_STOP;
            ptr        <= '0;
            xfer_addr  <= '0;
            d_addr     <= '0;
            d_len      <= '0;
            d_act      <= ACT_NOP;
            d_end      <= 1'b0;
            d_int      <= 1'b0;
            remaining  <= '0;
            stop_latch <= 1'b0;
            desc_req   <= 1'b0;
            xfer_req   <= 1'b0;
            desc_int   <= 1'b0;
            done       <= 1'b0;
            err_int    <= 1'b0;
            err_state  <= 2'b00;
        end else begin
            desc_int <= 1'b0;
            done     <= 1'b0;
            // NOTE: non-blocking updates resolve to the last write in this block, so the
            // clears further down override this same-cycle set of the stop latch.
            if (bus.stop_req) stop_latch <= 1'b1;

            case (state)
                ST_STOP: begin
                    if (bus.start) begin
                        ptr        <= bus.desc_base;
                        err_int    <= 1'b0;
                        stop_latch <= 1'b0;
                        desc_req   <= 1'b1;
                        state      <= ST_FDS;
                    end else if (bus.cont) begin
                        desc_req <= 1'b1;
                        state    <= ST_FDS;
                    end
                end

                ST_FDS: begin
                    if (bus.desc_ack) begin
                        ptr      <= ptr + PTR_STEP;
                        d_addr   <= bus.desc_data[ADDR_W+31:32];
                        d_len    <= bus.desc_data[16 +: LEN_W];
                        d_act    <= act_t'(bus.desc_data[5:4]);
                        d_end    <= bus.desc_data[1];
                        d_int    <= bus.desc_data[2];
                        desc_req <= 1'b0;
                        if (!bus.desc_data[0]) begin
                            err_int   <= 1'b1;
                            err_state <= ST_FDS;
                            state     <= ST_STOP;
                        end else begin
                            state <= ST_CADR;
                        end
                    end
                end

                ST_CADR: begin
                    if (d_act == ACT_TRAN) begin
                        if ((rem_init & CNT_MASK) != '0) begin
                            err_int   <= 1'b1;
                            err_state <= ST_CADR;
                            state     <= ST_STOP;
                        end else begin
                            xfer_addr <= d_addr;
                            remaining <= rem_init;
                            xfer_req  <= 1'b1;
                            state     <= ST_TFR;
                        end
                    end else begin
                        // Link, nop and reserved descriptors complete without moving data.
                        if (d_act == ACT_LINK) ptr <= d_addr;
                        desc_int <= d_int;
                        done     <= d_end;
                        if (d_end) begin
                            state <= ST_STOP;
                        end else begin
                            desc_req <= 1'b1;
                            state    <= ST_FDS;
                        end
                    end
                end

                ST_TFR: begin
                    if (bus.xfer_err) begin
                        xfer_req  <= 1'b0;
                        err_int   <= 1'b1;
                        err_state <= ST_TFR;
                        state     <= ST_STOP;
                    end else if (bus.xfer_beat) begin
                        xfer_addr <= xfer_addr + ADDR_STEP;
                        remaining <= remaining - CNT_STEP;
                        if (remaining == CNT_STEP) begin
                            xfer_req <= 1'b0;
                            desc_int <= d_int;
                            done     <= d_end;
                            if (d_end || stop_latch || bus.stop_req) begin
                                stop_latch <= 1'b0;
                                state      <= ST_STOP;
                            end else begin
                                desc_req <= 1'b1;
                                state    <= ST_FDS;
                            end
                        end
                    end
                end

                default: state <= ST_STOP;
            endcase
        end
    end

    assign bus.state     = state;
    assign bus.desc_req  = desc_req;
    assign bus.desc_addr = ptr;
    assign bus.xfer_req  = xfer_req;
    assign bus.xfer_addr = xfer_addr;
    assign bus.desc_int  = desc_int;
    assign bus.done      = done;
    assign bus.err_int   = err_int;
    assign bus.err_state = err_state;
endmodule

// File: tb/tb_adma_engine.sv
// Self-checking bench for adma_engine: directed scenarios plus randomized descriptor
// tables compared against a table-walking reference model.
module tb_adma_engine;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;
    localparam int BB     = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adma_engine_if #(.ADDR_W(ADDR_W)) bus ();

    adma_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BB)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [31:0]];

    logic [31:0] obs_fetch[$];
    logic [31:0] obs_beat[$];
    logic [31:0] exp_fetch[$];
    logic [31:0] exp_beat[$];
    int obs_done, obs_int, obs_xreq, last_beat_iter, done_iter;
    int exp_done, exp_int;
    bit timed_out;
    bit exp_err;
    logic [1:0]  exp_es;
    logic [31:0] exp_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [31:0] a, input logic [15:0] l,
                                       input bit v, input bit e, input bit i,
                                       input logic [1:0] act);
        logic [15:0] attr;
        attr      = '0;
        attr[0]   = v;
        attr[1]   = e;
        attr[2]   = i;
        attr[5:4] = act;
        return {a, l, attr};
    endfunction

    function automatic logic [63:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    task automatic clear_exp();
        exp_fetch.delete();
        exp_beat.delete();
        exp_done = 0;
        exp_int  = 0;
        exp_err  = 1'b0;
        exp_es   = 2'b00;
    endtask

    // Reference: walk the table the way the ADMA2 rules describe, descriptor by descriptor.
    task automatic model_walk(input logic [31:0] base);
        logic [31:0] p;
        logic [63:0] d;
        int len;
        clear_exp();
        p = base;
        for (int k = 0; k < 32; k++) begin
            exp_fetch.push_back(p);
            d = rd(p);
            p = p + 32'd8;
            if (!d[0]) begin
                exp_err = 1'b1; exp_es = 2'b01; break;
            end
            if (d[5:4] == 2'b10) begin
                len = (d[31:16] == 16'd0) ? 65536 : int'(d[31:16]);
                if (len % BB != 0) begin
                    exp_err = 1'b1; exp_es = 2'b10; break;
                end
                for (int b = 0; b < len; b += BB) exp_beat.push_back(d[63:32] + 32'(b));
            end else if (d[5:4] == 2'b11) begin
                p = d[63:32];
            end
            if (d[2]) exp_int++;
            if (d[1]) begin
                exp_done++; break;
            end
        end
        exp_ptr = p;
    endtask

    // Start/continue pulse; the engine must be fetching on the following cycle.
    task automatic kick(input bit s, input bit c, input string tag);
        @(negedge clk);
        bus.start = s;
        bus.cont  = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        check({tag, "_state"}, 64'(bus.state), 64'h1);
        check({tag, "_desc_req"}, 64'(bus.desc_req), 64'h1);
    endtask

    // Plays memory and data mover until the engine returns to stop or the budget expires.
    task automatic service(input int budget, input int stop_beat, input int err_beat);
        int beats;
        obs_fetch.delete();
        obs_beat.delete();
        obs_done = 0; obs_int = 0; obs_xreq = 0;
        last_beat_iter = -1; done_iter = -1;
        beats = 0;
        timed_out = 1'b1;
        for (int it = 0; it < budget; it++) begin
            @(negedge clk);
            bus.desc_ack  = 1'b0;
            bus.xfer_beat = 1'b0;
            bus.xfer_err  = 1'b0;
            bus.stop_req  = 1'b0;
            if (bus.done) begin
                obs_done++; done_iter = it;
            end
            if (bus.desc_int) obs_int++;
            if (it > 0 && bus.state == 2'b00) begin
                timed_out = 1'b0; break;
            end
            if (bus.desc_req && $urandom_range(0, 2) != 0) begin
                bus.desc_ack  = 1'b1;
                bus.desc_data = rd(bus.desc_addr);
                obs_fetch.push_back(bus.desc_addr);
            end
            if (bus.xfer_req) begin
                obs_xreq++;
                if ($urandom_range(0, 3) != 0) begin
                    bus.xfer_beat = 1'b1;
                    obs_beat.push_back(bus.xfer_addr);
                    last_beat_iter = it;
                    if (beats == stop_beat) bus.stop_req = 1'b1;
                    if (beats == err_beat)  bus.xfer_err = 1'b1;
                    beats++;
                end
            end
        end
        bus.desc_ack = 1'b0; bus.xfer_beat = 1'b0; bus.xfer_err = 1'b0; bus.stop_req = 1'b0;
        check("timeout", 64'(timed_out), 64'h0);
    endtask

    task automatic cmp_walk(input string tag);
        int n;
        check({tag, "_nfetch"}, 64'(obs_fetch.size()), 64'(exp_fetch.size()));
        n = (obs_fetch.size() < exp_fetch.size()) ? obs_fetch.size() : exp_fetch.size();
        for (int i = 0; i < n; i++) check({tag, "_fetch"}, 64'(obs_fetch[i]), 64'(exp_fetch[i]));
        check({tag, "_nbeat"}, 64'(obs_beat.size()), 64'(exp_beat.size()));
        n = (obs_beat.size() < exp_beat.size()) ? obs_beat.size() : exp_beat.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, 64'(obs_beat[i]), 64'(exp_beat[i]));
        check({tag, "_done"}, 64'(obs_done), 64'(exp_done));
        check({tag, "_int"}, 64'(obs_int), 64'(exp_int));
    endtask

    task automatic rand_scenario(input int idx);
        logic [31:0] base, p, tgt;
        int n, kind;
        bit last;
        mem.delete();
        base = 32'h1_0000 + 32'($urandom_range(0, 255)) * 32'd8;
        p = base;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            kind = $urandom_range(0, 9);
            if (last && (idx % 4 == 3)) begin
                if (kind < 5) mem[p] = 64'h0;
                else mem[p] = mk($urandom, 16'(4 * $urandom_range(0, 7) + 2), 1, 1, 0, 2'b10);
            end else if (kind == 0 && !last) begin
                tgt = 32'h4_0000 * 32'(k + 1) + 32'($urandom_range(0, 63)) * 32'd8;
                mem[p] = mk(tgt, 16'($urandom), 1, 0, 1'($urandom), 2'b11);
                p = tgt;
            end else if (kind == 1) begin
                mem[p] = mk($urandom, 16'($urandom), 1, last, 1'($urandom), 2'($urandom_range(0, 1)));
                p = p + 32'd8;
            end else begin
                mem[p] = mk($urandom, 16'(4 * $urandom_range(1, 8)), 1, last, 1'($urandom), 2'b10);
                p = p + 32'd8;
            end
        end
        model_walk(base);
        bus.desc_base = base;
        kick(1, 0, "rnd_go");
        service(3000, -1, -1);
        cmp_walk("rnd");
        check("rnd_err_int", 64'(bus.err_int), 64'(exp_err));
        if (exp_err) check("rnd_err_state", 64'(bus.err_state), 64'(exp_es));
        check("rnd_ptr", 64'(bus.desc_addr), 64'(exp_ptr));
    endtask

    initial begin
        bus.start = 0; bus.cont = 0; bus.stop_req = 0; bus.desc_base = '0;
        bus.desc_ack = 0; bus.desc_data = '0; bus.xfer_beat = 0; bus.xfer_err = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(bus.state), 64'h0);
        check("rst_desc_req", 64'(bus.desc_req), 64'h0);
        check("rst_xfer_req", 64'(bus.xfer_req), 64'h0);
        check("rst_desc_addr", 64'(bus.desc_addr), 64'h0);
        check("rst_xfer_addr", 64'(bus.xfer_addr), 64'h0);
        check("rst_flags", 64'({bus.done, bus.desc_int, bus.err_int, bus.err_state}), 64'h0);

        // Single tran, End=1, 16 bytes at 0x1000.
        mem[32'h100] = mk(32'h1000, 16'd16, 1, 1, 0, 2'b10);
        bus.desc_base = 32'h100;
        kick(1, 0, "t1_go");
        service(200, -1, -1);
        clear_exp();
        exp_fetch = '{32'h100};
        exp_beat  = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        exp_done  = 1;
        cmp_walk("t1");
        check("t1_done_latency", 64'(done_iter), 64'(last_beat_iter + 1));
        @(negedge clk);
        check("t1_done_width", 64'(bus.done), 64'h0);

        // Tran 8, link to 0x2000 (Int on link), tran End=1.
        mem[32'h200]  = mk(32'h3000, 16'd8, 1, 0, 0, 2'b10);
        mem[32'h208]  = mk(32'h2000, 16'd0, 1, 0, 1, 2'b11);
        mem[32'h2000] = mk(32'h5000, 16'd4, 1, 1, 0, 2'b10);
        bus.desc_base = 32'h200;
        kick(1, 0, "t2_go");
        service(300, -1, -1);
        clear_exp();
        exp_fetch = '{32'h200, 32'h208, 32'h2000};
        exp_beat  = '{32'h3000, 32'h3004, 32'h5000};
        exp_done  = 1;
        exp_int   = 1;
        cmp_walk("t2");
        check("t2_ptr", 64'(bus.desc_addr), 64'h2008);

        // Invalid first descriptor.
        mem[32'h300]  = 64'h0;
        bus.desc_base = 32'h300;
        kick(1, 0, "t3_go");
        service(100, -1, -1);
        check("t3_err_int", 64'(bus.err_int), 64'h1);
        check("t3_err_state", 64'(bus.err_state), 64'h1);
        check("t3_xfer_req", 64'(obs_xreq), 64'h0);
        bus.desc_base = 32'h100;
        kick(1, 0, "t3_restart");
        check("t3_err_clear", 64'(bus.err_int), 64'h0);
        service(200, -1, -1);

        // Stop request mid-transfer, then stop coincident with a last beat, then resume.
        mem[32'h400] = mk(32'h6000, 16'd16, 1, 0, 0, 2'b10);
        mem[32'h408] = mk(32'h7000, 16'd8, 1, 0, 0, 2'b10);
        mem[32'h410] = mk(32'h7100, 16'd4, 1, 1, 0, 2'b10);
        bus.desc_base = 32'h400;
        kick(1, 0, "t4_go");
        service(200, 1, -1);
        clear_exp();
        exp_fetch = '{32'h400};
        exp_beat  = '{32'h6000, 32'h6004, 32'h6008, 32'h600C};
        cmp_walk("t4a");
        check("t4a_ptr", 64'(bus.desc_addr), 64'h408);
        kick(0, 1, "t4b_go");
        service(200, 1, -1);
        clear_exp();
        exp_fetch = '{32'h408};
        exp_beat  = '{32'h7000, 32'h7004};
        cmp_walk("t4b");
        check("t4b_ptr", 64'(bus.desc_addr), 64'h410);
        kick(0, 1, "t4c_go");
        service(200, -1, -1);
        clear_exp();
        exp_fetch = '{32'h410};
        exp_beat  = '{32'h7100};
        exp_done  = 1;
        cmp_walk("t4c");
        check("t4_err_int", 64'(bus.err_int), 64'h0);

        // Bus error on the last beat beats the completion.
        mem[32'h500] = mk(32'h8000, 16'd8, 1, 1, 1, 2'b10);
        bus.desc_base = 32'h500;
        kick(1, 0, "t5_go");
        service(200, -1, 1);
        check("t5_err_int", 64'(bus.err_int), 64'h1);
        check("t5_err_state", 64'(bus.err_state), 64'h3);
        check("t5_done", 64'(obs_done), 64'h0);
        check("t5_int", 64'(obs_int), 64'h0);

        // Length 0 means 2^LEN_W bytes; data address wraps past the top.
        mem[32'h600] = mk(32'hFFFF_FFF0, 16'd0, 1, 1, 0, 2'b10);
        bus.desc_base = 32'h600;
        kick(1, 0, "t6_go");
        service(40000, -1, -1);
        clear_exp();
        exp_fetch = '{32'h600};
        for (int b = 0; b < 65536; b += BB) exp_beat.push_back(32'hFFFF_FFF0 + 32'(b));
        exp_done = 1;
        cmp_walk("t6");

        // Length not a multiple of the beat size.
        mem[32'h700] = mk(32'h9000, 16'd6, 1, 1, 0, 2'b10);
        bus.desc_base = 32'h700;
        kick(1, 0, "t7_go");
        service(100, -1, -1);
        check("t7_err_int", 64'(bus.err_int), 64'h1);
        check("t7_err_state", 64'(bus.err_state), 64'h2);
        check("t7_xfer_req", 64'(obs_xreq), 64'h0);

        // START and CONTINUE together: START reloads the pointer.
        bus.desc_base = 32'h100;
        kick(1, 1, "t8_go");
        check("t8_ptr", 64'(bus.desc_addr), 64'h100);
        check("t8_err_clear", 64'(bus.err_int), 64'h0);
        service(200, -1, -1);
        check("t8_done", 64'(obs_done), 64'h1);

        // Reset in the middle of a long transfer.
        bus.desc_base = 32'h600;
        kick(1, 0, "t9_go");
        repeat (12) begin
            @(negedge clk);
            bus.desc_ack  = bus.desc_req;
            bus.desc_data = rd(bus.desc_addr);
            bus.xfer_beat = bus.xfer_req;
        end
        check("t9_busy", 64'(bus.state), 64'h3);
        bus.desc_ack = 0; bus.xfer_beat = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t9_state", 64'(bus.state), 64'h0);
        check("t9_outs", 64'({bus.xfer_req, bus.desc_req, bus.done, bus.desc_int}), 64'h0);
        check("t9_addrs", 64'({bus.desc_addr, bus.xfer_addr}), 64'h0);

        for (int s = 0; s < 16; s++) rand_scenario(s);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
